ddr_capture_writer: RTL and testbench

Capture engine directly upstream of the `mem64ro` register block. It takes a stream of 64-bit DDR samples and writes them into the `DdrCapturesIndex` RAM through that block's user-side RAM port. Pre-trigger samples are stored in a circular buffer, and capture stops a programmable number of samples after a trigger. Arming comes from `regA_field0_o`; the resulting status is exposed for software readout.

---
 rtl/ddr_capture_pkg.sv | 18 +
 rtl/ddr_capture_writer_if.sv | 23 ++
 rtl/ddr_capture_writer.sv | 167 ++++++++++++++++
 tb/tb_ddr_capture_writer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_capture_pkg.sv
// ddr_capture_pkg
//   Shared types and constants for the DDR capture writer.
//   t_cap_state      : capture FSM state encoding
//   C_CAP_ADDR_WIDTH : default RAM address width (64-entry buffer)
//   C_CAP_DATA_WIDTH : default sample / RAM word width
package ddr_capture_pkg;

    localparam int C_CAP_ADDR_WIDTH = 6;
    localparam int C_CAP_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } t_cap_state;

endpackage

// File: rtl/ddr_capture_writer_if.sv
// ddr_capture_writer_if
//   RAM write port between the capture writer and the DdrCapturesIndex RAM
//   user port of the register block.
//   ram_adr_o : word address
//   ram_we_o  : one-cycle write strobe per stored sample
//   ram_dat_o : sample data
//   master : the capture writer (drives the port)
//   slave  : the RAM / register block (receives the port)
interface ddr_capture_writer_if
    import ddr_capture_pkg::*;
#(
    parameter int g_addr_width = C_CAP_ADDR_WIDTH,
    parameter int g_data_width = C_CAP_DATA_WIDTH
);

    logic [g_addr_width-1:0] ram_adr_o;
    logic                    ram_we_o;
    logic [g_data_width-1:0] ram_dat_o;

    modport master (output ram_adr_o, output ram_we_o, output ram_dat_o);
    modport slave  (input  ram_adr_o, input  ram_we_o, input  ram_dat_o);

endinterface

// File: rtl/ddr_capture_writer.sv
// ddr_capture_writer
//   Writes a stream of DDR samples into a circular RAM buffer. Samples are
//   stored continuously once armed; after a qualified trigger a programmable
//   number of further samples is stored and the capture stops.
//   Sample stream: smp_valid_i qualifies smp_dat_i and trig_i in the same
//   cycle; there is no back-pressure, every valid sample is taken.
// Ports
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   arm_i              : arm level; rising edge arms, falling edge aborts
//   trig_i             : trigger, qualified by smp_valid_i
//   post_count_i       : samples to store after the trigger sample
//   smp_valid_i/dat_i  : sample stream
//   ram_o              : RAM write port (master side)
//   busy_o             : capture in progress (ARMED or POST)
//   done_o             : capture complete, held until re-arm or reset
//   trig_adr_o         : RAM address of the trigger sample
//   oldest_adr_o       : address of the oldest valid entry
//   wrapped_o          : write pointer wrapped since arming
//   state_o            : current FSM state (debug)
module ddr_capture_writer
    import ddr_capture_pkg::*;
#(
    parameter int g_addr_width = C_CAP_ADDR_WIDTH,
    parameter int g_data_width = C_CAP_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    arm_i,
    input  logic                    trig_i,
    input  logic [g_addr_width-1:0] post_count_i,
    input  logic                    smp_valid_i,
    input  logic [g_data_width-1:0] smp_dat_i,
    ddr_capture_writer_if.master    ram_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [g_addr_width-1:0] trig_adr_o,
    output logic [g_addr_width-1:0] oldest_adr_o,
    output logic                    wrapped_o,
    output t_cap_state              state_o
);

    localparam logic [g_addr_width-1:0] C_ONE = g_addr_width'(1);

    t_cap_state              state_q, state_d;
    logic                    arm_q;
    logic [g_addr_width-1:0] ptr_q, ptr_d;
    logic [g_addr_width-1:0] rem_q, rem_d;
    logic                    wrapped_q, wrapped_d;
    logic                    done_q, done_d;
    logic [g_addr_width-1:0] trig_adr_q, trig_adr_d;
    logic                    we_q, we_d;
    logic [g_addr_width-1:0] adr_q, adr_d;
    logic [g_data_width-1:0] dat_q, dat_d;

    logic rise, fall, start, wr;

    assign rise  = arm_i & ~arm_q;
    assign fall  = ~arm_i & arm_q;
    // Arming is only possible from IDLE or DONE; a rise elsewhere cannot occur
    // because arm_i must have fallen (and aborted) first.
    assign start = rise && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        wrapped_d  = wrapped_q;
        done_d     = done_q;
        trig_adr_d = trig_adr_q;
        we_d       = 1'b0;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wr         = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // The sample coinciding with the arming edge is dropped.
                if (start) begin
                    state_d    = ARMED;
                    ptr_d      = '0;
                    wrapped_d  = 1'b0;
                    done_d     = 1'b0;
                    trig_adr_d = '0;
                end
            end
            ARMED: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (smp_valid_i) begin
                    wr = 1'b1;
                    if (trig_i) begin
                        trig_adr_d = ptr_q;
                        rem_d      = post_count_i;
                        if (post_count_i == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = POST;
                        end
                    end
                end
            end
            POST: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (smp_valid_i) begin
                    wr    = 1'b1;
                    rem_d = rem_q - C_ONE;
                    if (rem_q == C_ONE) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr) begin
            we_d  = 1'b1;
            adr_d = ptr_q;
            dat_d = smp_dat_i;
            ptr_d = ptr_q + C_ONE;
            if (ptr_q == '1) begin
                wrapped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            ptr_q      <= '0;
            rem_q      <= '0;
            wrapped_q  <= 1'b0;
            done_q     <= 1'b0;
            trig_adr_q <= '0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_i;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            wrapped_q  <= wrapped_d;
            done_q     <= done_d;
            trig_adr_q <= trig_adr_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    assign ram_o.ram_we_o  = we_q;
    assign ram_o.ram_adr_o = adr_q;
    assign ram_o.ram_dat_o = dat_q;

    assign busy_o       = (state_q == ARMED) || (state_q == POST);
    assign done_o       = done_q;
    assign trig_adr_o   = trig_adr_q;
    assign wrapped_o    = wrapped_q;
    // Once wrapped, the next slot to be written holds the oldest sample.
    assign oldest_adr_o = wrapped_q ? ptr_q : '0;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ddr_capture_writer.sv
// tb_ddr_capture_writer
//   Self-checking bench for ddr_capture_writer: a table of directed capture
//   scenarios, hand-written abort/reset sequences and randomized captures
//   checked against a sample-list reference model.
module tb_ddr_capture_writer;
    import ddr_capture_pkg::*;

    localparam int AW = 6;
    localparam int DW = 64;
    localparam int WW = 1 + AW + DW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm   = 1'b0;
    logic          trig  = 1'b0;
    logic          valid = 1'b0;
    logic [AW-1:0] post  = '0;
    logic [DW-1:0] dat   = '0;

    logic          busy, done, wrapped;
    logic [AW-1:0] trig_adr, oldest;
    t_cap_state    state;

    ddr_capture_writer_if #(.g_addr_width(AW), .g_data_width(DW)) ram_if ();

    ddr_capture_writer #(.g_addr_width(AW), .g_data_width(DW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .arm_i        (arm),
        .trig_i       (trig),
        .post_count_i (post),
        .smp_valid_i  (valid),
        .smp_dat_i    (dat),
        .ram_o        (ram_if.master),
        .busy_o       (busy),
        .done_o       (done),
        .trig_adr_o   (trig_adr),
        .oldest_adr_o (oldest),
        .wrapped_o    (wrapped),
        .state_o      (state)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: each write is {done at that write, address, data}
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] act_q[$];

    always @(posedge clk) begin
        #1;
        if (ram_if.ram_we_o === 1'b1)
            act_q.push_back({done, ram_if.ram_adr_o, ram_if.ram_dat_o});
    end

    typedef struct {
        int total;
        int trig_at;
        int post;
        int gap;
        int exp_writes;
        int exp_trig;
        bit exp_wrapped;
        int exp_oldest;
        bit exp_done;
    } vec_t;

    vec_t vecs[6];

    logic          v_a[256];
    logic          t_a[256];
    logic [AW-1:0] p_a[256];
    logic [DW-1:0] d_a[256];

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drivers
    task automatic step(input logic v, input logic t, input logic [AW-1:0] p, input logic [DW-1:0] d);
        valid = v;
        trig  = t;
        post  = p;
        dat   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, '0);
    endtask

    // Arming edge coincides with a valid triggering sample, which must be dropped.
    task automatic arm_up();
        arm = 1'b0;
        idle(2);
        arm = 1'b1;
        step(1'b1, 1'b1, 6'd0, 64'hdead_beef_0bad_f00d);
    endtask

    task automatic check_writes(input string name);
        int n;
        chk({name, ".n_writes"}, WW'(act_q.size()), WW'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s.write[%0d]", name, i), act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string name, input bit e_done, input bit e_busy,
                                input int e_trig, input bit e_wrapped,
                                input bit chk_oldest, input int e_oldest);
        chk({name, ".done"}, WW'(done), WW'(e_done));
        chk({name, ".busy"}, WW'(busy), WW'(e_busy));
        chk({name, ".trig_adr"}, WW'(trig_adr), WW'(e_trig));
        chk({name, ".wrapped"}, WW'(wrapped), WW'(e_wrapped));
        if (chk_oldest)
            chk({name, ".oldest"}, WW'(oldest), WW'(e_oldest));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, ".we"}, WW'(ram_if.ram_we_o), '0);
        chk({name, ".adr"}, WW'(ram_if.ram_adr_o), '0);
        chk({name, ".dat"}, WW'(ram_if.ram_dat_o), '0);
        chk({name, ".busy"}, WW'(busy), '0);
        chk({name, ".done"}, WW'(done), '0);
        chk({name, ".trig_adr"}, WW'(trig_adr), '0);
        chk({name, ".oldest"}, WW'(oldest), '0);
        chk({name, ".wrapped"}, WW'(wrapped), '0);
        chk({name, ".state"}, WW'(state), WW'(IDLE));
    endtask

    // Reference model: list the valid samples, find the first qualified
    // trigger, and keep samples up to trigger + post count.
    task automatic model_check(input string name, input int len);
        logic [DW-1:0] vs[$];
        int  k = -1;
        int  kp = 0;
        int  n_wr;
        bit  m_done;
        bit  m_wrap;
        for (int c = 0; c < len; c++) begin
            if (v_a[c]) begin
                if (k < 0 && t_a[c]) begin
                    k  = vs.size();
                    kp = int'(p_a[c]);
                end
                vs.push_back(d_a[c]);
            end
        end
        if (k < 0) n_wr = vs.size();
        else       n_wr = (k + kp + 1 < vs.size()) ? k + kp + 1 : vs.size();
        m_done = (k >= 0) && (vs.size() >= k + kp + 1);
        m_wrap = (n_wr >= 64);
        for (int i = 0; i < n_wr; i++)
            exp_q.push_back({(i == n_wr - 1) && m_done, AW'(i % 64), vs[i]});
        check_writes(name);
        check_status(name, m_done, !m_done, (k >= 0) ? k % 64 : 0, m_wrap,
                     m_done, m_wrap ? n_wr % 64 : 0);
    endtask

    initial begin
        //                total trig post gap writes trig wrap oldest done
        vecs[0] = '{10,  4,   3,  0,  8,   4,  1'b0, 0,  1'b1};
        vecs[1] = '{115, 100, 10, 0,  111, 36, 1'b1, 47, 1'b1};
        vecs[2] = '{8,   5,   0,  0,  6,   5,  1'b0, 0,  1'b1};
        vecs[3] = '{9,   -1,  0,  2,  9,   0,  1'b0, 0,  1'b0};
        vecs[4] = '{64,  63,  0,  0,  64,  63, 1'b1, 0,  1'b1};
        vecs[5] = '{70,  0,   63, 0,  64,  0,  1'b1, 0,  1'b1};

        // reset
        idle(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);
        check_all_zero("post_reset_idle");

        // table-driven scenarios
        for (int r = 0; r < 6; r++) begin
            arm_up();
            for (int i = 0; i < vecs[r].total; i++) begin
                for (int g = 0; g < vecs[r].gap; g++)
                    step(1'b0, (g == 0) ? 1'b1 : 1'b0, 6'd0, 64'(g + 1000));
                step(1'b1, (i == vecs[r].trig_at), AW'(vecs[r].post), DW'(i));
            end
            idle(3);
            for (int i = 0; i < vecs[r].exp_writes; i++)
                exp_q.push_back({(i == vecs[r].exp_writes - 1) && vecs[r].exp_done, AW'(i % 64), DW'(i)});
            check_writes($sformatf("vec%0d", r));
            check_status($sformatf("vec%0d", r), vecs[r].exp_done, !vecs[r].exp_done,
                         vecs[r].exp_trig, vecs[r].exp_wrapped, 1'b1, vecs[r].exp_oldest);
        end

        // abort during POST, then re-arm restarts at address 0
        arm_up();
        step(1'b1, 1'b0, 6'd0, 64'd100);
        step(1'b1, 1'b0, 6'd0, 64'd101);
        step(1'b1, 1'b1, 6'd20, 64'd102);
        step(1'b1, 1'b0, 6'd0, 64'd103);
        step(1'b1, 1'b0, 6'd0, 64'd104);
        arm = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 6'd0, 64'(105 + i));
        idle(2);
        for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, AW'(i), DW'(100 + i)});
        check_writes("abort");
        check_status("abort", 1'b0, 1'b0, 2, 1'b0, 1'b0, 0);
        chk("abort.state", WW'(state), WW'(IDLE));
        arm_up();
        step(1'b1, 1'b0, 6'd0, 64'd200);
        step(1'b1, 1'b0, 6'd0, 64'd201);
        idle(2);
        exp_q.push_back({1'b0, 6'd0, 64'd200});
        exp_q.push_back({1'b0, 6'd1, 64'd201});
        check_writes("rearm");
        check_status("rearm", 1'b0, 1'b1, 0, 1'b0, 1'b0, 0);

        // asynchronous reset mid-POST with valid held high
        arm_up();
        step(1'b1, 1'b0, 6'd0, 64'd300);
        step(1'b1, 1'b1, 6'd30, 64'd301);
        step(1'b1, 1'b0, 6'd0, 64'd302);
        valid = 1'b1;
        dat   = 64'd303;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        arm   = 1'b0;
        #1;
        check_all_zero("async_reset");
        act_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 6'd0, 64'(400 + i));
        idle(2);
        check_writes("after_reset");
        chk("after_reset.busy", WW'(busy), '0);

        // randomized captures against the reference model
        for (int it = 0; it < 25; it++) begin
            int len;
            arm_up();
            len = $urandom_range(20, 160);
            for (int c = 0; c < len; c++) begin
                v_a[c] = ($urandom_range(0, 9) < 7);
                t_a[c] = ($urandom_range(0, 19) == 0);
                p_a[c] = AW'($urandom_range(0, 63));
                d_a[c] = {$urandom, $urandom};
                step(v_a[c], t_a[c], p_a[c], d_a[c]);
            end
            idle(3);
            model_check($sformatf("rand%0d", it), len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
